// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the memory-mapped SPI master.
// Register offsets relative to BASE_ADDR, STATUS/CTRL bit positions and the
// transfer FSM state encoding (also exported on the dbg_state port).
package spi_pkg;

    localparam logic [31:0] OFF_CTRL   = 32'h0000_0000;
    localparam logic [31:0] OFF_DATA   = 32'h0000_0004;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0008;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVR  = 2;

    localparam int CTRL_FAST   = 0;
    localparam int CTRL_IRQ_EN = 7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_LOW  = 3'd2,
        S_HIGH = 3'd3,
        S_DONE = 3'd4
    } spi_state_t;

endpackage

// File: rtl/spi_mmio_if.sv
// spi_mmio_if: processor data-bus port of the SPI master.
// Handshake: wReadEnable / wWriteEnable are single-cycle strobes qualified by
// wAddress; there is no ready/wait signal, a write takes effect on the rising
// clock edge where the strobe is high, and wReadData is valid combinationally
// in the same cycle as wReadEnable (a DATA read's side effect lands on that edge).
interface spi_mmio_if;

    logic        wReadEnable;
    logic        wWriteEnable;
    logic [3:0]  wByteEnable;
    logic [31:0] wAddress;
    logic [31:0] wWriteData;
    logic [31:0] wReadData;

    modport master (
        output wReadEnable, wWriteEnable, wByteEnable, wAddress, wWriteData,
        input  wReadData
    );

    modport slave (
        input  wReadEnable, wWriteEnable, wByteEnable, wAddress, wWriteData,
        output wReadData
    );

endinterface

// File: rtl/spi_clk_div.sv
// spi_clk_div: loadable down-counter that sets the SCLK half-period.
// tick is high while the count is zero; a load restarts the count so the
// following half-period lasts load_val+1 cycles.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Reload on request, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/spi_mmio_master.sv
// spi_mmio_master: memory-mapped SPI master (mode 0, MSB first) with
// CTRL/DATA/STATUS registers, slow/fast SCLK dividers and NUM_CS chip selects.
// Optional feature macro SPI_IRQ_EN: adds the oIRQ port and the CTRL bit7
// irq_en gate; without it CTRL bit7 reads 0 and ignores writes.
module spi_mmio_master
    import spi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0250,
    parameter int          NUM_CS    = 1,
    parameter int          DIV_SLOW  = 124,
    parameter int          DIV_FAST  = 0,
    parameter int          DIV_W     = 8
) (
    input  logic              iCLK,
    input  logic              Reset,
    spi_mmio_if.slave         bus,
    output logic              SD_CLK,
    output logic              SD_MOSI,
    input  logic              SD_MISO,
    output logic [NUM_CS-1:0] SD_CS,
`ifdef SPI_IRQ_EN
    output logic              oIRQ,
`endif
    output spi_state_t        dbg_state
);

    localparam logic [DIV_W-1:0] DIV_SLOW_V = DIV_W'(DIV_SLOW);
    localparam logic [DIV_W-1:0] DIV_FAST_V = DIV_W'(DIV_FAST);

    spi_state_t        state;
    logic              fast;
    logic [NUM_CS-1:0] cs_sel;
    logic              busy;
    logic              done;
    logic              ovr;
    logic [7:0]        tx;
    logic [7:0]        rx;
    logic [DIV_W-1:0]  div_q;
    logic [2:0]        bit_cnt;
`ifdef SPI_IRQ_EN
    logic              irq_en;
`endif

    logic sel_ctrl, sel_data, sel_status;
    logic wr_ctrl, wr_data, wr_status, rd_data;
    logic div_load, div_tick;
    logic [31:0] ctrl_rd;
    logic [31:0] status_rd;
    logic unused_bits;

    // Full-address decode; only byte lane 0 qualifies writes.
    assign sel_ctrl   = (bus.wAddress == BASE_ADDR + OFF_CTRL);
    assign sel_data   = (bus.wAddress == BASE_ADDR + OFF_DATA);
    assign sel_status = (bus.wAddress == BASE_ADDR + OFF_STATUS);

    assign wr_ctrl   = bus.wWriteEnable && bus.wByteEnable[0] && sel_ctrl;
    assign wr_data   = bus.wWriteEnable && bus.wByteEnable[0] && sel_data;
    assign wr_status = bus.wWriteEnable && bus.wByteEnable[0] && sel_status;
    assign rd_data   = bus.wReadEnable && sel_data;

    assign unused_bits = &{1'b0, bus.wByteEnable[3:1], bus.wWriteData};

    assign SD_CS     = ~cs_sel;
    assign dbg_state = state;

    // The divider restarts at LOAD and at every SCLK half-period boundary.
    assign div_load = (state == S_LOAD) ||
                      (((state == S_LOW) || (state == S_HIGH)) && div_tick);

    spi_clk_div #(
        .DIV_W(DIV_W)
    ) u_clk_div (
        .clk     (iCLK),
        .rst     (Reset),
        .load    (div_load),
        .load_val(div_q),
        .tick    (div_tick)
    );

    // CTRL readback, zero-extended.
    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_FAST] = fast;
        ctrl_rd[NUM_CS:1] = cs_sel;
`ifdef SPI_IRQ_EN
        ctrl_rd[CTRL_IRQ_EN] = irq_en;
`endif
    end

    // STATUS readback: busy, sticky done, sticky overrun.
    always_comb begin
        status_rd = '0;
        status_rd[STAT_BUSY] = busy;
        status_rd[STAT_DONE] = done;
        status_rd[STAT_OVR]  = ovr;
    end

    // Read mux: zero whenever no mapped register is being read.
    always_comb begin
        bus.wReadData = '0;
        if (bus.wReadEnable) begin
            if (sel_ctrl) begin
                bus.wReadData = ctrl_rd;
            end else if (sel_data) begin
                bus.wReadData = {24'b0, rx};
            end else if (sel_status) begin
                bus.wReadData = status_rd;
            end
        end
    end

    // Register file and transfer FSM; FSM updates come last so a DONE set of
    // 'done' wins over a simultaneous DATA-read clear.
    always_ff @(posedge iCLK) begin
        if (Reset) begin
            state   <= S_IDLE;
            SD_CLK  <= 1'b0;
            SD_MOSI <= 1'b1;
            fast    <= 1'b0;
            cs_sel  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovr     <= 1'b0;
            tx      <= 8'h00;
            rx      <= 8'hFF;
            div_q   <= '0;
            bit_cnt <= 3'd0;
`ifdef SPI_IRQ_EN
            irq_en  <= 1'b0;
            oIRQ    <= 1'b0;
`endif
        end else begin
`ifdef SPI_IRQ_EN
            oIRQ <= 1'b0;
`endif
            // CS and speed are frozen while a byte is in flight.
            if (wr_ctrl) begin
                if (busy) begin
                    ovr <= 1'b1;
                end else begin
                    fast   <= bus.wWriteData[CTRL_FAST];
                    cs_sel <= bus.wWriteData[NUM_CS:1];
`ifdef SPI_IRQ_EN
                    irq_en <= bus.wWriteData[CTRL_IRQ_EN];
`endif
                end
            end
            if (wr_data && busy) begin
                ovr <= 1'b1;
            end
            if (wr_status) begin
                ovr <= 1'b0;
            end
            if (rd_data) begin
                done <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (wr_data) begin
                        tx    <= bus.wWriteData[7:0];
                        div_q <= fast ? DIV_FAST_V : DIV_SLOW_V;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    SD_MOSI <= tx[7];
                    bit_cnt <= 3'd0;
                    state   <= S_LOW;
                end
                S_LOW: begin
                    if (div_tick) begin
                        SD_CLK <= 1'b1;
                        rx     <= {rx[6:0], SD_MISO};
                        state  <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (div_tick) begin
                        SD_CLK <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            SD_MOSI <= 1'b1;
                            state   <= S_DONE;
`ifdef SPI_IRQ_EN
                            oIRQ    <= irq_en;
`endif
                        end else begin
                            tx      <= {tx[6:0], 1'b0};
                            SD_MOSI <= tx[6];
                            bit_cnt <= bit_cnt + 3'd1;
                            state   <= S_LOW;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mmio_master.sv
// tb_spi_mmio_master: self-checking bench for spi_mmio_master.
// A behavioural SPI slave shifts out miso_byte MSB first and collects MOSI
// bytes on rising SCLK; expected bytes, latencies and register values come
// from a small register model and the byte-timing formula.
module tb_spi_mmio_master;
    import spi_pkg::*;

    localparam logic [31:0] BASE     = 32'hFFFF0250;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_DATA   = BASE + 32'd4;
    localparam logic [31:0] A_STAT   = BASE + 32'd8;
    localparam int          NUM_CS   = 1;
    localparam int          DIV_SLOW = 124;
    localparam int          DIV_FAST = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_mmio_if bus ();
    logic              sd_clk;
    logic              sd_mosi;
    logic              sd_miso;
    logic [NUM_CS-1:0] sd_cs;
    spi_state_t        dbg_state;
`ifdef SPI_IRQ_EN
    logic              irq;
`endif

    spi_mmio_master #(
        .BASE_ADDR(BASE),
        .NUM_CS   (NUM_CS),
        .DIV_SLOW (DIV_SLOW),
        .DIV_FAST (DIV_FAST),
        .DIV_W    (8)
    ) dut (
        .iCLK     (clk),
        .Reset    (rst),
        .bus      (bus),
        .SD_CLK   (sd_clk),
        .SD_MOSI  (sd_mosi),
        .SD_MISO  (sd_miso),
        .SD_CS    (sd_cs),
`ifdef SPI_IRQ_EN
        .oIRQ     (irq),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- SPI slave model + scoreboard ----------------
    logic [7:0] miso_byte = 8'hFF;
    logic [2:0] miso_idx  = 3'd0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         sclk_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         irq_cnt = 0;

    assign sd_miso = miso_byte[3'd7 - miso_idx];

    // Slave advances to its next bit on every falling SCLK.
    initial begin
        forever begin
            @(negedge sd_clk or posedge rst);
            if (rst) miso_idx = 3'd0;
            else     miso_idx = miso_idx + 3'd1;
        end
    end

    // Slave captures MOSI on rising SCLK and assembles bytes.
    initial begin
        logic [7:0] cur;
        int nbits;
        cur = 8'h00;
        nbits = 0;
        forever begin
            @(posedge sd_clk or posedge rst);
            if (rst) begin
                nbits = 0;
            end else begin
                cur = {cur[6:0], sd_mosi};
                nbits++;
                if (nbits == 8) begin
                    got_q.push_back(cur);
                    nbits = 0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int exp_latency(input bit f);
        return 16 * ((f ? DIV_FAST : DIV_SLOW) + 1) + 2;
    endfunction

    function automatic logic [31:0] exp_ctrl(input logic [31:0] wr);
        logic [31:0] mask;
        mask = (32'd1 << (NUM_CS + 1)) - 32'd1;
`ifdef SPI_IRQ_EN
        mask = mask | 32'h80;
`endif
        return wr & mask;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
        bus.wWriteEnable = 1'b1;
        bus.wAddress     = addr;
        bus.wWriteData   = data;
        bus.wByteEnable  = be;
        @(negedge clk);
        bus.wWriteEnable = 1'b0;
        bus.wByteEnable  = 4'h0;
    endtask

    // Combinational look at a register; no clock edge sees the strobe.
    task automatic peek(input logic [31:0] addr, output logic [31:0] data);
        bus.wReadEnable = 1'b1;
        bus.wAddress    = addr;
        #1;
        data = bus.wReadData;
        bus.wReadEnable = 1'b0;
    endtask

    // Read held across one rising edge so its side effect takes place.
    task automatic read_commit(input logic [31:0] addr, output logic [31:0] data);
        bus.wReadEnable = 1'b1;
        bus.wAddress    = addr;
        #1;
        data = bus.wReadData;
        @(negedge clk);
        bus.wReadEnable = 1'b0;
    endtask

    // Counts cycles until STATUS.busy drops, recording SCLK each cycle.
    task automatic wait_idle(input int max, output int cycles);
        logic [31:0] st;
        cycles = 0;
        sclk_q.delete();
        do begin
            @(negedge clk);
            cycles++;
            sclk_q.push_back(sd_clk);
`ifdef SPI_IRQ_EN
            if (irq) irq_cnt++;
`endif
            peek(A_STAT, st);
        end while (st[0] && cycles <= max);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] r;
        n_cmp++; if (sd_clk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk got=%b exp=0", sd_clk); end
        n_cmp++; if (sd_mosi !== 1'b1) begin n_bad++; $display("FAIL reset_mosi got=%b exp=1", sd_mosi); end
        n_cmp++; if (sd_cs !== {NUM_CS{1'b1}}) begin n_bad++; $display("FAIL reset_cs got=%b", sd_cs); end
        peek(A_STAT, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_status got=%h exp=0", r); end
        peek(A_DATA, r);
        n_cmp++; if (r !== 32'hFF) begin n_bad++; $display("FAIL reset_rx got=%h exp=ff", r); end
        peek(A_CTRL, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl got=%h exp=0", r); end
    endtask

    task automatic test_fast_byte();
        logic [31:0] r;
        int cyc;
        bus_write(A_CTRL, 32'h03, 4'hF);
        n_cmp++; if (sd_cs[0] !== 1'b0) begin n_bad++; $display("FAIL fast_cs got=%b exp=0", sd_cs[0]); end
        miso_byte = 8'h3C;
        got_q.delete();
        exp_q.push_back(8'hA5);
        bus_write(A_DATA, 32'hA5, 4'hF);
        wait_idle(100, cyc);
        n_cmp++; if (cyc !== exp_latency(1'b1)) begin n_bad++; $display("FAIL fast_latency got=%0d exp=%0d", cyc, exp_latency(1'b1)); end
        n_cmp++;
        if (got_q.size() == 0) begin n_bad++; $display("FAIL fast_mosi got=none exp=a5"); exp_q.delete(); end
        else if (got_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL fast_mosi got=%h exp=%h", got_q[0], exp_q[0]); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        peek(A_STAT, r);
        n_cmp++; if (r !== 32'h2) begin n_bad++; $display("FAIL fast_status got=%h exp=2", r); end
        read_commit(A_DATA, r);
        n_cmp++; if (r !== 32'h3C) begin n_bad++; $display("FAIL fast_rx got=%h exp=3c", r); end
        peek(A_STAT, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL fast_done_clear got=%h exp=0", r); end
    endtask

    task automatic test_slow_mode();
        int cyc;
        int run_len;
        bit run_val;
        int hi_runs[$];
        int lo_runs[$];
        logic [31:0] r;
        bus_write(A_CTRL, 32'h02, 4'hF);
        miso_byte = 8'h81;
        got_q.delete();
        bus_write(A_DATA, 32'hFF, 4'hF);
        wait_idle(2500, cyc);
        n_cmp++; if (cyc !== exp_latency(1'b0)) begin n_bad++; $display("FAIL slow_latency got=%0d exp=%0d", cyc, exp_latency(1'b0)); end
        run_val = sclk_q[0];
        run_len = 0;
        foreach (sclk_q[i]) begin
            if (sclk_q[i] == run_val) begin
                run_len++;
            end else begin
                if (run_val) hi_runs.push_back(run_len);
                else         lo_runs.push_back(run_len);
                run_val = sclk_q[i];
                run_len = 1;
            end
        end
        n_cmp++; if (hi_runs.size() !== 8) begin n_bad++; $display("FAIL slow_high_count got=%0d exp=8", hi_runs.size()); end
        foreach (hi_runs[i]) begin
            n_cmp++; if (hi_runs[i] !== DIV_SLOW + 1) begin n_bad++; $display("FAIL slow_high_len[%0d] got=%0d exp=%0d", i, hi_runs[i], DIV_SLOW + 1); end
        end
        for (int i = 1; i < lo_runs.size(); i++) begin
            n_cmp++; if (lo_runs[i] !== DIV_SLOW + 1) begin n_bad++; $display("FAIL slow_low_len[%0d] got=%0d exp=%0d", i, lo_runs[i], DIV_SLOW + 1); end
        end
        n_cmp++;
        if (got_q.size() == 0) begin n_bad++; $display("FAIL slow_mosi got=none exp=ff"); end
        else if (got_q[0] !== 8'hFF) begin n_bad++; $display("FAIL slow_mosi got=%h exp=ff", got_q[0]); end
        read_commit(A_DATA, r);
        n_cmp++; if (r !== 32'h81) begin n_bad++; $display("FAIL slow_rx got=%h exp=81", r); end
    endtask

    task automatic test_overrun();
        logic [31:0] r;
        int cyc;
        bus_write(A_CTRL, 32'h03, 4'hF);
        miso_byte = 8'h00;
        got_q.delete();
        bus_write(A_DATA, 32'h11, 4'hF);
        bus_write(A_DATA, 32'h22, 4'hF);
        bus_write(A_CTRL, 32'h00, 4'hF);
        peek(A_STAT, r);
        n_cmp++; if (r !== 32'h5) begin n_bad++; $display("FAIL ovr_status_busy got=%h exp=5", r); end
        n_cmp++; if (sd_cs[0] !== 1'b0) begin n_bad++; $display("FAIL ovr_cs got=%b exp=0", sd_cs[0]); end
        wait_idle(100, cyc);
        n_cmp++; if (cyc !== exp_latency(1'b1) - 2) begin n_bad++; $display("FAIL ovr_latency got=%0d exp=%0d", cyc, exp_latency(1'b1) - 2); end
        peek(A_STAT, r);
        n_cmp++; if (r !== 32'h6) begin n_bad++; $display("FAIL ovr_status_done got=%h exp=6", r); end
        n_cmp++;
        if (got_q.size() == 0) begin n_bad++; $display("FAIL ovr_mosi got=none exp=11"); end
        else if (got_q[0] !== 8'h11) begin n_bad++; $display("FAIL ovr_mosi got=%h exp=11", got_q[0]); end
        peek(A_CTRL, r);
        n_cmp++; if (r !== 32'h3) begin n_bad++; $display("FAIL ovr_ctrl got=%h exp=3", r); end
        bus_write(A_STAT, 32'h0, 4'hF);
        peek(A_STAT, r);
        n_cmp++; if (r !== 32'h2) begin n_bad++; $display("FAIL ovr_clear got=%h exp=2", r); end
        read_commit(A_DATA, r);
        peek(A_STAT, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL ovr_done_clear got=%h exp=0", r); end
    endtask

    task automatic test_done_read_race();
        logic [31:0] r;
        bus_write(A_CTRL, 32'h03, 4'hF);
        bus_write(A_DATA, 32'h5A, 4'hF);
        // Hold a DATA read through the edge that finishes the byte.
        bus.wReadEnable = 1'b1;
        bus.wAddress    = A_DATA;
        repeat (exp_latency(1'b1)) @(negedge clk);
        bus.wReadEnable = 1'b0;
        peek(A_STAT, r);
        n_cmp++; if (r !== 32'h2) begin n_bad++; $display("FAIL race_done got=%h exp=2", r); end
        read_commit(A_DATA, r);
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        int rises;
        int budget;
        bit prev;
        bus_write(A_CTRL, 32'h02, 4'hF);
        miso_byte = 8'h5A;
        got_q.delete();
        bus_write(A_DATA, 32'h00, 4'hF);
        rises = 0;
        budget = 0;
        prev = sd_clk;
        while (rises < 4 && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (sd_clk && !prev) rises++;
            prev = sd_clk;
        end
        n_cmp++; if (rises !== 4) begin n_bad++; $display("FAIL rmid_reach_bit4 got=%0d exp=4", rises); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (sd_clk !== 1'b0) begin n_bad++; $display("FAIL rmid_sclk got=%b exp=0", sd_clk); end
        n_cmp++; if (sd_mosi !== 1'b1) begin n_bad++; $display("FAIL rmid_mosi got=%b exp=1", sd_mosi); end
        n_cmp++; if (sd_cs !== {NUM_CS{1'b1}}) begin n_bad++; $display("FAIL rmid_cs got=%b", sd_cs); end
        peek(A_STAT, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL rmid_status got=%h exp=0", r); end
        peek(A_DATA, r);
        n_cmp++; if (r !== 32'hFF) begin n_bad++; $display("FAIL rmid_rx got=%h exp=ff", r); end
        peek(A_CTRL, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL rmid_ctrl got=%h exp=0", r); end
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL rmid_partial got=%0d bytes exp=0", got_q.size()); end
    endtask

    task automatic test_bus_decode();
        logic [31:0] r;
        logic [31:0] addr;
        int rises;
        bit prev;
        peek(BASE + 32'hC, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL dec_unmapped_hi got=%h exp=0", r); end
        peek(BASE - 32'h4, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL dec_unmapped_lo got=%h exp=0", r); end
        addr = {$urandom_range(0, 32'h7FFF), 16'h0};
        peek(addr, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL dec_unmapped_rand addr=%h got=%h exp=0", addr, r); end
        bus_write(A_CTRL, 32'h03, 4'b0010);
        peek(A_CTRL, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL dec_ctrl_lane got=%h exp=0", r); end
        bus_write(A_CTRL, 32'h83, 4'hF);
        peek(A_CTRL, r);
        n_cmp++; if (r !== exp_ctrl(32'h83)) begin n_bad++; $display("FAIL dec_ctrl_rb got=%h exp=%h", r, exp_ctrl(32'h83)); end
        bus_write(BASE + 32'h10, 32'h00, 4'hF);
        peek(A_CTRL, r);
        n_cmp++; if (r !== exp_ctrl(32'h83)) begin n_bad++; $display("FAIL dec_stray_write got=%h exp=%h", r, exp_ctrl(32'h83)); end
        bus_write(A_DATA, 32'hC3, 4'b0010);
        rises = 0;
        prev = sd_clk;
        repeat (30) begin
            @(negedge clk);
            if (sd_clk && !prev) rises++;
            prev = sd_clk;
        end
        n_cmp++; if (rises !== 0) begin n_bad++; $display("FAIL dec_lane_no_xfer sclk_rises=%0d exp=0", rises); end
        peek(A_STAT, r);
        n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL dec_lane_status got=%h exp=0", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [31:0] ctrl;
        logic [7:0] tx;
        logic [7:0] mb;
        bit f;
        int cs;
        int cyc;
        for (int i = 0; i < 10; i++) begin
            f  = ($urandom_range(0, 3) != 0);
            cs = $urandom_range(0, (1 << NUM_CS) - 1);
            ctrl = (32'(cs) << 1) | 32'(f);
            bus_write(A_CTRL, ctrl, 4'hF);
            n_cmp++; if (sd_cs !== ~NUM_CS'(cs)) begin n_bad++; $display("FAIL b2b_cs[%0d] got=%b exp=%b", i, sd_cs, ~NUM_CS'(cs)); end
            tx = 8'($urandom);
            mb = 8'($urandom);
            miso_byte = mb;
            got_q.delete();
            exp_q.push_back(tx);
            bus_write(A_DATA, {24'($urandom), tx}, 4'hF);
            wait_idle(2500, cyc);
            n_cmp++; if (cyc !== exp_latency(f)) begin n_bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, cyc, exp_latency(f)); end
            n_cmp++;
            if (got_q.size() == 0) begin n_bad++; $display("FAIL b2b_mosi[%0d] got=none exp=%h", i, exp_q[0]); end
            else if (got_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL b2b_mosi[%0d] got=%h exp=%h", i, got_q[0], exp_q[0]); end
            void'(exp_q.pop_front());
            read_commit(A_DATA, r);
            n_cmp++; if (r !== {24'h0, mb}) begin n_bad++; $display("FAIL b2b_rx[%0d] got=%h exp=%h", i, r, mb); end
            peek(A_STAT, r);
            n_cmp++; if (r !== 32'h0) begin n_bad++; $display("FAIL b2b_status[%0d] got=%h exp=0", i, r); end
        end
    endtask

`ifdef SPI_IRQ_EN
    task automatic test_irq();
        logic [31:0] r;
        int cyc;
        irq_cnt = 0;
        bus_write(A_CTRL, 32'h83, 4'hF);
        bus_write(A_DATA, 32'h3C, 4'hF);
        wait_idle(100, cyc);
        repeat (5) begin
            @(negedge clk);
            if (irq) irq_cnt++;
        end
        n_cmp++; if (irq_cnt !== 1) begin n_bad++; $display("FAIL irq_on got=%0d pulses exp=1", irq_cnt); end
        read_commit(A_DATA, r);
        irq_cnt = 0;
        bus_write(A_CTRL, 32'h03, 4'hF);
        bus_write(A_DATA, 32'hC3, 4'hF);
        wait_idle(100, cyc);
        repeat (5) begin
            @(negedge clk);
            if (irq) irq_cnt++;
        end
        n_cmp++; if (irq_cnt !== 0) begin n_bad++; $display("FAIL irq_off got=%0d pulses exp=0", irq_cnt); end
        read_commit(A_DATA, r);
    endtask
`endif

    // ---------------- sequence and final report ----------------
    initial begin
        bus.wReadEnable  = 1'b0;
        bus.wWriteEnable = 1'b0;
        bus.wByteEnable  = 4'h0;
        bus.wAddress     = 32'h0;
        bus.wWriteData   = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_fast_byte();
        test_slow_mode();
        test_overrun();
        test_done_read_race();
        test_reset_mid();
        test_bus_decode();
        test_back_to_back();
`ifdef SPI_IRQ_EN
        test_irq();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
